// File: rtl/pipeline_pkg.sv
// Shared helpers for the elastic pipeline buffer: pointer wrap, count width
// and the messages raised when occupancy leaves its legal range.
package pipeline_pkg;

    localparam string MSG_OVERFLOW  = "occupancy overflow: push while full";
    localparam string MSG_UNDERFLOW = "occupancy underflow: pop while empty";
    localparam string MSG_RANGE     = "occupancy exceeds Depth";

    function automatic int cnt_width(int depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap by compare so non-power-of-2 depths work.
    function automatic int ptr_inc(int ptr, int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipeline_fifo_mem.sv
// Token storage: one synchronous write port, one asynchronous read port,
// kept separate so it maps onto distributed RAM.
module pipeline_fifo_mem #(
    parameter int Width = 8,
    parameter int Depth = 4,
    localparam int AW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_fifo_buf.sv
// Depth-slot elastic pipeline buffer with valid/backpressure handshake.
// Define PIPELINE_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module pipeline_fifo_buf
    import pipeline_pkg::*;
#(
    parameter string Name  = "",
    parameter int    Width = 8,
    parameter int    Depth = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [Width-1:0]           d,
    input  logic                       d_valid,
    output logic                       d_bp,
    output logic [Width-1:0]           q,
    output logic                       q_valid,
    input  logic                       q_bp,
    input  logic                       flush,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = cnt_width(Depth);
    localparam int PW = $clog2(Depth);

    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [Width-1:0] rdata;
    logic             byp;
    logic             incoming;
    logic             outgoing;
    logic             wr;
    logic             rd;

    assign count = count_q;
    assign full  = (count_q == CW'(Depth));
    assign empty = (count_q == '0);
    assign d_bp  = full | flush;

`ifdef PIPELINE_FIFO_BYPASS_EN
    assign byp = empty & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign q_valid  = byp ? d_valid : (~empty & ~flush);
    assign q        = byp ? d : rdata;
    assign incoming = d_valid & ~d_bp;
    assign outgoing = q_valid & ~q_bp;

    // A bypassed token that leaves this cycle is never stored.
    assign wr = incoming & ~(byp & outgoing);
    assign rd = outgoing & ~byp;

    pipeline_fifo_mem #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr & ~flush),
        .waddr (tail_q),
        .wdata (d),
        .raddr (head_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) begin
                tail_q <= PW'(ptr_inc(int'(tail_q), Depth));
            end
            if (rd) begin
                head_q <= PW'(ptr_inc(int'(head_q), Depth));
            end
            case ({wr, rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            assert (!(wr && !rd && full))
                else $error("%s: %s", Name, MSG_OVERFLOW);
            assert (!(rd && !wr && empty))
                else $error("%s: %s", Name, MSG_UNDERFLOW);
            assert (count_q <= CW'(Depth))
                else $error("%s: %s", Name, MSG_RANGE);
        end
    end

endmodule
